// File: rtl/iob_wb_bridge.sv
// iob_wb_bridge: IOb-native slave to Wishbone classic (B3) master bridge.
// Latency: request registered in cycle 0, cyc/stb in cycle 1, rvalid one cycle after ack/err/timeout.
// Backpressure: iob_ready_o is low for the whole Wishbone cycle; one transfer in flight at a time.
//
// Ports:
//   clk_i, arst_i (async, active-high)
//   IOb side : iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i, iob_ready_o,
//              iob_rvalid_o, iob_rdata_o
//   Status   : err_o (sticky), err_clr_i
//   WB side  : wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
//              wb_dat_i, wb_ack_i, wb_err_i
// Optional feature macro: IOB_WB_BRIDGE_TIMEOUT_EN (bus timeout counter).
module iob_wb_bridge #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int WB_ADDR_W = 8,
   parameter int TIMEOUT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   input  logic                 iob_avalid_i,
   input  logic [ADDR_W-1:0]    iob_addr_i,
   input  logic [DATA_W-1:0]    iob_wdata_i,
   input  logic [DATA_W/8-1:0]  iob_wstrb_i,
   output logic                 iob_ready_o,
   output logic                 iob_rvalid_o,
   output logic [DATA_W-1:0]    iob_rdata_o,
   output logic                 err_o,
   input  logic                 err_clr_i,
   output logic [WB_ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0]    wb_dat_o,
   output logic [DATA_W/8-1:0]  wb_sel_o,
   output logic                 wb_we_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   input  logic [DATA_W-1:0]    wb_dat_i,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i
);

   localparam int SEL_W = DATA_W / 8;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [WB_ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0]    dat_q, dat_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 we_q, we_d;
   logic                 cyc_q, cyc_d;
   logic                 rvalid_q, rvalid_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 err_set;
   logic                 timeout;

   // Upper IOb address bits select the peripheral upstream; only LSBs are forwarded.
   logic unused_addr;
   assign unused_addr = ^iob_addr_i;

`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
   // Counter value during the n-th BUSY cycle is n-1; the cycle in which it
   // would step onto all-ones is the last BUSY cycle.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE)   cnt_d = '0;
      else if (!timeout)     cnt_d = cnt_q + 1'b1;
   end

   assign timeout = (state_q == BUSY) && (cnt_q == TO_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q  <= IDLE;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
         cyc_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         cyc_q    <= cyc_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      sel_d    = sel_q;
      we_d     = we_q;
      cyc_d    = cyc_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      err_set  = 1'b0;

      case (state_q)
         IDLE: begin
            if (iob_avalid_i) begin
               adr_d   = iob_addr_i[WB_ADDR_W-1:0];
               dat_d   = iob_wdata_i;
               we_d    = |iob_wstrb_i;
               sel_d   = (|iob_wstrb_i) ? iob_wstrb_i : {SEL_W{1'b1}};
               cyc_d   = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (wb_err_i || wb_ack_i || timeout) begin
               cyc_d   = 1'b0;
               state_d = IDLE;
               // err has priority over ack; timeout only matters when neither is present.
               err_set = wb_err_i || (!wb_ack_i && timeout);
               if (!we_q) begin
                  rvalid_d = 1'b1;
                  rdata_d  = (wb_ack_i && !wb_err_i) ? wb_dat_i : {DATA_W{1'b1}};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A new error in the same cycle as a clear keeps the flag set.
      err_d = err_q;
      if (err_clr_i) err_d = 1'b0;
      if (err_set)   err_d = 1'b1;
   end

   assign iob_ready_o  = (state_q == IDLE);
   assign iob_rvalid_o = rvalid_q;
   assign iob_rdata_o  = rdata_q;
   assign err_o        = err_q;
   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = dat_q;
   assign wb_sel_o     = sel_q;
   assign wb_we_o      = we_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;

endmodule

// File: tb/tb_iob_wb_bridge.sv
module tb_iob_wb_bridge;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int WAW = 8;
`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
   localparam int TW  = 4;
`else
   localparam int TW  = 8;
`endif

   logic           clk_i = 1'b0;
   logic           arst_i;
   logic           iob_avalid_i;
   logic [AW-1:0]  iob_addr_i;
   logic [DW-1:0]  iob_wdata_i;
   logic [3:0]     iob_wstrb_i;
   logic           iob_ready_o;
   logic           iob_rvalid_o;
   logic [DW-1:0]  iob_rdata_o;
   logic           err_o;
   logic           err_clr_i;
   logic [WAW-1:0] wb_adr_o;
   logic [DW-1:0]  wb_dat_o;
   logic [3:0]     wb_sel_o;
   logic           wb_we_o;
   logic           wb_cyc_o;
   logic           wb_stb_o;
   logic [DW-1:0]  wb_dat_i;
   logic           wb_ack_i;
   logic           wb_err_i;

   iob_wb_bridge #(.ADDR_W(AW), .DATA_W(DW), .WB_ADDR_W(WAW), .TIMEOUT_W(TW)) dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
      .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
      .iob_rdata_o(iob_rdata_o), .err_o(err_o), .err_clr_i(err_clr_i),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference state: last completed read data and sticky error flag.
   logic [DW-1:0] rdata_exp;
   logic          err_exp;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One complete IOb transfer; slave answers after dly extra BUSY cycles.
   // Returns in the completion cycle, so a following call is back-to-back.
   task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input int dly, input bit do_err, input bit do_ack,
                      input logic [31:0] sdat, input bit clr_at_term);
      bit rd;
      rd = (ws == 4'h0);
      iob_avalid_i = 1'b1;
      iob_addr_i   = a;
      iob_wdata_i  = wd;
      iob_wstrb_i  = ws;
      chk("ready_idle", 64'(iob_ready_o), 64'(1));
      tick();
      iob_avalid_i = 1'b0;
      iob_addr_i   = $urandom;
      iob_wdata_i  = $urandom;
      iob_wstrb_i  = 4'($urandom);
      chk("cyc", 64'(wb_cyc_o), 64'(1));
      chk("stb", 64'(wb_stb_o), 64'(1));
      chk("adr", 64'(wb_adr_o), 64'(a[7:0]));
      chk("we",  64'(wb_we_o),  64'(!rd));
      chk("sel", 64'(wb_sel_o), rd ? 64'(4'hF) : 64'(ws));
      chk("wdat", 64'(wb_dat_o), 64'(wd));
      chk("ready_busy", 64'(iob_ready_o), 64'(0));
      chk("rvalid_gap", 64'(iob_rvalid_o), 64'(0));
      for (int i = 0; i < dly; i++) begin
         tick();
         chk("cyc_hold", 64'(wb_cyc_o), 64'(1));
      end
      wb_ack_i  = do_ack;
      wb_err_i  = do_err;
      wb_dat_i  = sdat;
      err_clr_i = clr_at_term;
      tick();
      wb_ack_i  = 1'b0;
      wb_err_i  = 1'b0;
      wb_dat_i  = $urandom;
      err_clr_i = 1'b0;
      if (rd) rdata_exp = do_err ? 32'hFFFF_FFFF : sdat;
      if (clr_at_term) err_exp = 1'b0;
      if (do_err)      err_exp = 1'b1;
      chk("cyc_done",   64'(wb_cyc_o),     64'(0));
      chk("stb_done",   64'(wb_stb_o),     64'(0));
      chk("ready_done", 64'(iob_ready_o),  64'(1));
      chk("rvalid",     64'(iob_rvalid_o), 64'(rd));
      chk("rdata",      64'(iob_rdata_o),  64'(rdata_exp));
      chk("err",        64'(err_o),        64'(err_exp));
   endtask

   task automatic clear_err();
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      err_exp   = 1'b0;
      chk("err_clr", 64'(err_o), 64'(0));
   endtask

   initial begin
      arst_i       = 1'b1;
      iob_avalid_i = 1'b0;
      iob_addr_i   = '0;
      iob_wdata_i  = '0;
      iob_wstrb_i  = '0;
      err_clr_i    = 1'b0;
      wb_dat_i     = '0;
      wb_ack_i     = 1'b0;
      wb_err_i     = 1'b0;
      rdata_exp    = '0;
      err_exp      = 1'b0;

      #12;
      chk("rst_ready",  64'(iob_ready_o),  64'(1));
      chk("rst_rvalid", 64'(iob_rvalid_o), 64'(0));
      chk("rst_rdata",  64'(iob_rdata_o),  64'(0));
      chk("rst_err",    64'(err_o),        64'(0));
      chk("rst_cyc",    64'(wb_cyc_o),     64'(0));
      chk("rst_stb",    64'(wb_stb_o),     64'(0));
      chk("rst_we",     64'(wb_we_o),      64'(0));
      chk("rst_adr",    64'(wb_adr_o),     64'(0));
      chk("rst_sel",    64'(wb_sel_o),     64'(0));
      chk("rst_wdat",   64'(wb_dat_o),     64'(0));
      #11 arst_i = 1'b0;
      tick();

      // Write, ack in cycle 3.
      txn(32'h0000_000C, 32'hA5A5_0011, 4'h3, 2, 1'b0, 1'b1, 32'h0, 1'b0);
      // Back-to-back reads with combinational ack.
      txn(32'h0000_0004, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
      txn(32'h0000_0008, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
      tick();
      chk("rvalid_pulse", 64'(iob_rvalid_o), 64'(0));
      // err together with ack: err wins.
      txn(32'h0000_0010, 32'h0, 4'h0, 1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      clear_err();
      // Clear in the same cycle as a new error: error stays set.
      txn(32'h0000_0014, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h5555_5555, 1'b1);
      clear_err();
      // Write terminated by err: flag set, no rvalid, rdata unchanged.
      txn(32'h0000_0018, 32'h7777_0000, 4'hC, 1, 1'b1, 1'b0, 32'h0, 1'b0);
      clear_err();

      // Slave never answers.
      iob_avalid_i = 1'b1;
      iob_addr_i   = 32'h20;
      iob_wstrb_i  = 4'h0;
      tick();
      iob_avalid_i = 1'b0;
`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
      begin
         int n;
         n = 0;
         while (wb_cyc_o && n < 60) begin
            n++;
            tick();
         end
         rdata_exp = 32'hFFFF_FFFF;
         err_exp   = 1'b1;
         chk("to_busy_cycles", 64'(n), 64'(15));
         chk("to_rvalid", 64'(iob_rvalid_o), 64'(1));
         chk("to_rdata",  64'(iob_rdata_o),  64'(rdata_exp));
         chk("to_err",    64'(err_o),        64'(1));
         chk("to_ready",  64'(iob_ready_o),  64'(1));
      end
      clear_err();
`else
      repeat (120) tick();
      chk("hang_cyc",   64'(wb_cyc_o),    64'(1));
      chk("hang_ready", 64'(iob_ready_o), 64'(0));
      chk("hang_err",   64'(err_o),       64'(0));
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hCAFE_0001;
      tick();
      wb_ack_i  = 1'b0;
      rdata_exp = 32'hCAFE_0001;
      chk("hang_rvalid", 64'(iob_rvalid_o), 64'(1));
      chk("hang_rdata",  64'(iob_rdata_o),  64'(rdata_exp));
`endif

      // Asynchronous reset in cycle 2 of a pending read.
      iob_avalid_i = 1'b1;
      iob_addr_i   = 32'h24;
      iob_wstrb_i  = 4'h0;
      tick();
      iob_avalid_i = 1'b0;
      tick();
      #2 arst_i = 1'b1;
      #1;
      chk("arst_cyc",   64'(wb_cyc_o),    64'(0));
      chk("arst_stb",   64'(wb_stb_o),    64'(0));
      chk("arst_ready", 64'(iob_ready_o), 64'(1));
      rdata_exp = '0;
      err_exp   = 1'b0;
      @(negedge clk_i);
      arst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("arst_no_rvalid", 64'(iob_rvalid_o), 64'(0));
         chk("arst_idle_cyc",  64'(wb_cyc_o),     64'(0));
      end
      txn(32'h0000_0028, 32'h0, 4'h0, 1, 1'b0, 1'b1, 32'h0F0F_1234, 1'b0);

      // Randomized traffic against the transaction-level model.
      for (int t = 0; t < 60; t++) begin
         logic [3:0] ws;
         bit         e, k, c;
         ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         e  = ($urandom_range(0, 4) == 0);
         k  = !e || ($urandom_range(0, 1) == 1);
         c  = ($urandom_range(0, 7) == 0);
         txn($urandom, $urandom, ws, $urandom_range(0, 3), e, k, $urandom, c);
         if ($urandom_range(0, 2) == 0) begin
            tick();
            chk("rnd_gap_rvalid", 64'(iob_rvalid_o), 64'(0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
